// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS stopwatch kept as four BCD digits.
// Counts on the 1 Hz tick while running. In adjust mode the selected field
// steps on the 2 Hz tick, and a blink phase on the 4 Hz tick blanks that field.
// All outputs are registered, so every change appears one clock after its cause.
module stopwatch_counter #(
  parameter int MIN_MAX      = 59,
  parameter bit RUN_AT_RESET = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       tick_4hz,
  input  logic       pause,
  input  logic       adj_en,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       blank_min,
  output logic       blank_sec,
  output logic       wrap
);

  localparam logic [3:0] MAX_T = 4'(MIN_MAX / 10);
  localparam logic [3:0] MAX_O = 4'(MIN_MAX % 10);

  logic       phase;
  logic       sec_at_max;
  logic       min_at_max;
  logic       count_evt;
  logic       adj_sec_evt;
  logic       adj_min_evt;
  logic       phase_nxt;
  logic [3:0] sec_tens_inc;
  logic [3:0] sec_ones_inc;
  logic [3:0] min_tens_inc;
  logic [3:0] min_ones_inc;

  // Incremented digit values and the events that decide which field moves.
  // The count and adjust events are mutually exclusive on adj_en, so at most
  // one increment happens per cycle. The count event uses the running value
  // from before any pause toggle in the same cycle.
  always_comb begin
    sec_at_max   = (sec_tens == 4'd5) && (sec_ones == 4'd9);
    min_at_max   = (min_tens == MAX_T) && (min_ones == MAX_O);
    count_evt    = ~adj_en & tick_1hz & running;
    adj_sec_evt  = adj_en & tick_2hz & sel;
    adj_min_evt  = adj_en & tick_2hz & ~sel;
    phase_nxt    = adj_en ? (phase ^ tick_4hz) : 1'b0;
    sec_tens_inc = sec_tens;
    sec_ones_inc = sec_ones + 4'd1;
    if (sec_ones == 4'd9) begin
      sec_ones_inc = 4'd0;
      sec_tens_inc = sec_at_max ? 4'd0 : sec_tens + 4'd1;
    end
    min_tens_inc = min_tens;
    min_ones_inc = min_ones + 4'd1;
    if (min_at_max) begin
      min_tens_inc = 4'd0;
      min_ones_inc = 4'd0;
    end else if (min_ones == 4'd9) begin
      min_tens_inc = min_tens + 4'd1;
      min_ones_inc = 4'd0;
    end
  end

  // Time, run state, blink phase and the registered blank/wrap outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_tens  <= 4'd0;
      min_ones  <= 4'd0;
      sec_tens  <= 4'd0;
      sec_ones  <= 4'd0;
      running   <= RUN_AT_RESET;
      phase     <= 1'b0;
      blank_min <= 1'b0;
      blank_sec <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      wrap <= count_evt & sec_at_max & min_at_max;
      if (count_evt || adj_sec_evt) begin
        sec_tens <= sec_tens_inc;
        sec_ones <= sec_ones_inc;
      end
      // Minutes move on a counting carry out of :59, or directly when adjusted.
      if ((count_evt && sec_at_max) || adj_min_evt) begin
        min_tens <= min_tens_inc;
        min_ones <= min_ones_inc;
      end
      running   <= running ^ pause;
      phase     <= phase_nxt;
      blank_min <= adj_en & ~sel & phase_nxt;
      blank_sec <= adj_en & sel & phase_nxt;
    end
  end

endmodule
